// File: rtl/radiant_trig_gen_pkg.sv
// Shared constants for the trigger generator: source bit indices,
// event_info_o field layout and the qualification FSM state encoding.
package radiant_trig_gen_pkg;

  // Trigger source bit positions in the candidate vector and mask
  localparam int unsigned NUM_SRC  = 3;
  localparam int unsigned SRC_SOFT = 0;
  localparam int unsigned SRC_EXT  = 1;
  localparam int unsigned SRC_PPS  = 2;

  // Counter and output widths
  localparam int unsigned OUTST_W    = 3;
  localparam int unsigned MISSED_W   = 16;
  localparam int unsigned DEADTIME_W = 32;

  // event_info_o layout; bits not covered by a field read zero
  localparam int unsigned INFO_W          = 32;
  localparam int unsigned INFO_SRC_LSB    = 0;
  localparam int unsigned INFO_SRC_W      = NUM_SRC;
  localparam int unsigned INFO_OUTST_LSB  = 4;
  localparam int unsigned INFO_OUTST_W    = OUTST_W;
  localparam int unsigned INFO_MISSED_LSB = 8;
  localparam int unsigned INFO_MISSED_W   = MISSED_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_e;

endpackage

// File: rtl/radiant_trig_edge_sync.sv
// 2-FF synchronizer followed by a rising-edge detector. The pulse is decoded
// from synchronized flops only, so it is glitch-free and one cycle wide; a
// level held high yields exactly one pulse.
module radiant_trig_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/radiant_trig_gen.sv
// Trigger qualification and event generation. Combines soft/ext/pps sources
// under a mask, enforces holdoff and the digitizer buffer budget, and emits a
// one-cycle event strobe with an info word. Tracks missed triggers and dead time.
// Build option: define RADIANT_TRIG_GEN_PPS_TRIG_EN to build the PPS trigger path;
// without it the PPS candidate bit is tied low and pps_i is ignored.
module radiant_trig_gen
  import radiant_trig_gen_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS   = 4,
  parameter int unsigned HOLDOFF_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trig_en_i,
  input  logic [NUM_SRC-1:0]       src_mask_i,
  input  logic                     soft_trig_i,
  input  logic                     ext_trig_i,
  input  logic                     pps_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
  input  logic                     event_ready_i,
  input  logic                     event_done_i,
  input  logic                     clear_i,
  output logic                     event_o,
  output logic [INFO_W-1:0]        event_info_o,
  output logic                     busy_o,
  output logic [OUTST_W-1:0]       outstanding_o,
  output logic [MISSED_W-1:0]      missed_o,
  output logic [DEADTIME_W-1:0]    deadtime_o,
  output logic                     underflow_o
);

  trig_state_e              state_q;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt_q;
  logic                     ext_rise_c;
  logic                     pps_rise_c;
  logic [NUM_SRC-1:0]       cand_c;
  logic                     cand_any_c;
  logic                     accept_c;
  logic [INFO_W-1:0]        info_c;

  radiant_trig_edge_sync u_ext_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (ext_trig_i),
    .rise_c  (ext_rise_c)
  );

`ifdef RADIANT_TRIG_GEN_PPS_TRIG_EN
  radiant_trig_edge_sync u_pps_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (pps_i),
    .rise_c  (pps_rise_c)
  );
`else
  logic unused_pps;
  assign unused_pps = pps_i;
  assign pps_rise_c = 1'b0;
`endif

  // Masked, globally enabled candidate vector
  always_comb begin
    cand_c           = '0;
    cand_c[SRC_SOFT] = soft_trig_i;
    cand_c[SRC_EXT]  = ext_rise_c;
    cand_c[SRC_PPS]  = pps_rise_c;
    cand_c           = cand_c & src_mask_i & {NUM_SRC{trig_en_i}};
  end

  assign cand_any_c = |cand_c;
  assign accept_c   = (state_q == ST_IDLE) &&
                      (outstanding_o < OUTST_W'(NUM_BUFFERS)) &&
                      event_ready_i;

  // Info word captured at acceptance: sources, pre-increment count, missed snapshot
  always_comb begin
    info_c                                       = '0;
    info_c[INFO_SRC_LSB    +: INFO_SRC_W]        = cand_c;
    info_c[INFO_OUTST_LSB  +: INFO_OUTST_W]      = outstanding_o;
    info_c[INFO_MISSED_LSB +: INFO_MISSED_W]     = missed_o;
  end

  // Qualification FSM: IDLE -> FIRE (one-cycle strobe) -> optional HOLDOFF
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      event_o      <= 1'b0;
      event_info_o <= '0;
    end else begin
      event_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cand_any_c && accept_c) begin
            state_q      <= ST_FIRE;
            event_o      <= 1'b1;
            event_info_o <= info_c;
          end
        end
        ST_FIRE: begin
          if (holdoff_i != '0) begin
            state_q    <= ST_HOLDOFF;
            hold_cnt_q <= holdoff_i;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          hold_cnt_q <= hold_cnt_q - HOLDOFF_WIDTH'(1);
          if (hold_cnt_q == HOLDOFF_WIDTH'(1)) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-event counter with sticky underflow on a spurious done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
      underflow_o   <= 1'b0;
    end else begin
      if ((state_q == ST_FIRE) && !event_done_i) begin
        outstanding_o <= outstanding_o + OUTST_W'(1);
      end else if ((state_q != ST_FIRE) && event_done_i) begin
        if (outstanding_o == '0) begin
          underflow_o <= 1'b1;
        end else begin
          outstanding_o <= outstanding_o - OUTST_W'(1);
        end
      end
    end
  end

  // Registered busy flag: trigger could not be accepted this cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o <= 1'b1;
    end else begin
      busy_o <= !accept_c;
    end
  end

  // Saturating missed-trigger and dead-time counters; clear has priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      missed_o   <= '0;
      deadtime_o <= '0;
    end else if (clear_i) begin
      missed_o   <= '0;
      deadtime_o <= '0;
    end else begin
      if (cand_any_c && !accept_c && (missed_o != '1)) begin
        missed_o <= missed_o + MISSED_W'(1);
      end
      if (trig_en_i && busy_o && (deadtime_o != '1)) begin
        deadtime_o <= deadtime_o + DEADTIME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_radiant_trig_gen.sv
// Directed bench for radiant_trig_gen with an event scoreboard: each expected
// event info word is queued when its trigger is driven and popped when event_o fires.
module tb_radiant_trig_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        trig_en = 1'b0;
  logic [2:0]  src_mask = 3'b000;
  logic        soft_trig = 1'b0;
  logic        ext_trig = 1'b0;
  logic        pps = 1'b0;
  logic [15:0] holdoff = 16'd0;
  logic        event_ready = 1'b0;
  logic        event_done = 1'b0;
  logic        clear = 1'b0;

  logic        event_o;
  logic [31:0] event_info_o;
  logic        busy_o;
  logic [2:0]  outstanding_o;
  logic [15:0] missed_o;
  logic [31:0] deadtime_o;
  logic        underflow_o;

  int checks = 0;
  int errors = 0;
  int n_events = 0;
  int n_pushed = 0;
  logic prev_evt = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  radiant_trig_gen #(
    .NUM_BUFFERS   (4),
    .HOLDOFF_WIDTH (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .trig_en_i     (trig_en),
    .src_mask_i    (src_mask),
    .soft_trig_i   (soft_trig),
    .ext_trig_i    (ext_trig),
    .pps_i         (pps),
    .holdoff_i     (holdoff),
    .event_ready_i (event_ready),
    .event_done_i  (event_done),
    .clear_i       (clear),
    .event_o       (event_o),
    .event_info_o  (event_info_o),
    .busy_o        (busy_o),
    .outstanding_o (outstanding_o),
    .missed_o      (missed_o),
    .deadtime_o    (deadtime_o),
    .underflow_o   (underflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_info(input logic [2:0] src, input logic [2:0] outst,
                                          input logic [15:0] missed);
    return {8'h00, missed, 1'b0, outst, 1'b0, src};
  endfunction

  task automatic expect_evt(input logic [31:0] info);
    exp_q.push_back(info);
    n_pushed++;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && event_o) begin
      n_events++;
      chk("evt_single_cycle", 32'(prev_evt), 32'd0);
      chk("evt_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("evt_info", event_info_o, exp_q.pop_front());
    end
    prev_evt = event_o;
  end

  initial begin
    int last_evt;

    trig_en     = 1'b1;
    src_mask    = 3'b001;
    event_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_event", 32'(event_o), 32'd0);
    chk("rst_info", event_info_o, 32'd0);
    chk("rst_outst", 32'(outstanding_o), 32'd0);
    chk("rst_missed", 32'(missed_o), 32'd0);
    chk("rst_deadtime", deadtime_o, 32'd0);
    chk("rst_underflow", 32'(underflow_o), 32'd0);
    #19 rst_n = 1'b1;
    tick(1);
    chk("p1_busy_release", 32'(busy_o), 32'd0);

    // First soft trigger after reset
    expect_evt(mk_info(3'b001, 3'd0, 16'd0));
    soft_trig = 1'b1; tick(1); soft_trig = 1'b0;
    chk("p1_evt", 32'(event_o), 32'd1);
    chk("p1_outst_pre", 32'(outstanding_o), 32'd0);
    tick(1);
    chk("p1_outst_post", 32'(outstanding_o), 32'd1);

    // Buffer budget: five pulses, four accepted
    event_done = 1'b1; tick(1); event_done = 1'b0;
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("p2_outst_start", 32'(outstanding_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_evt(mk_info(3'b001, 3'(i), 16'd0));
      soft_trig = 1'b1; tick(1); soft_trig = 1'b0;
      chk("p2_evt", 32'(event_o), (i < 4) ? 32'd1 : 32'd0);
      tick(2);
    end
    chk("p2_missed", 32'(missed_o), 32'd1);
    chk("p2_outst_full", 32'(outstanding_o), 32'd4);
    chk("p2_busy_full", 32'(busy_o), 32'd1);
    repeat (4) begin
      event_done = 1'b1; tick(1); event_done = 1'b0; tick(1);
    end
    chk("p2_outst_drained", 32'(outstanding_o), 32'd0);
    chk("p2_underflow", 32'(underflow_o), 32'd0);

    // Holdoff 10 with continuous soft requests: events 12 cycles apart
    clear = 1'b1; tick(1); clear = 1'b0;
    holdoff = 16'd10;
    expect_evt(mk_info(3'b001, 3'd0, 16'd0));
    expect_evt(mk_info(3'b001, 3'd0, 16'd11));
    expect_evt(mk_info(3'b001, 3'd0, 16'd22));
    last_evt = -1;
    soft_trig = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      event_done = event_o;
      if (event_o) begin
        if (last_evt >= 0) chk("p3_spacing", 32'(c - last_evt), 32'd12);
        last_evt = c;
      end
    end
    soft_trig = 1'b0;
    event_done = 1'b0;
    chk("p3_missed", 32'(missed_o), 32'd27);
    holdoff = 16'd0;
    tick(1);
    chk("p3_busy_holdoff", 32'(busy_o), 32'd1);
    tick(14);
    chk("p3_busy_done", 32'(busy_o), 32'd0);
    chk("p3_outst", 32'(outstanding_o), 32'd0);
    chk("p3_drained", 32'(exp_q.size()), 32'd0);

    // Ext edge and soft pulse in the same cycle merge into one event
    clear = 1'b1; tick(1); clear = 1'b0;
    src_mask = 3'b011;
    expect_evt(mk_info(3'b011, 3'd0, 16'd0));
    ext_trig = 1'b1;
    tick(1);
    tick(1);
    soft_trig = 1'b1; tick(1); soft_trig = 1'b0;
    chk("p4_evt", 32'(event_o), 32'd1);
    tick(10);
    chk("p4_single_edge", 32'(exp_q.size()), 32'd0);
    chk("p4_missed", 32'(missed_o), 32'd0);
    ext_trig = 1'b0;
    src_mask = 3'b001;
    tick(3);
    chk("p4_outst", 32'(outstanding_o), 32'd1);

    // Done coincident with FIRE leaves the count unchanged; done at zero underflows
    expect_evt(mk_info(3'b001, 3'd1, 16'd0));
    soft_trig = 1'b1; tick(1); soft_trig = 1'b0;
    tick(2);
    chk("p5_outst_two", 32'(outstanding_o), 32'd2);
    expect_evt(mk_info(3'b001, 3'd2, 16'd0));
    soft_trig = 1'b1; tick(1); soft_trig = 1'b0;
    chk("p5_evt", 32'(event_o), 32'd1);
    event_done = 1'b1; tick(1); event_done = 1'b0;
    tick(1);
    chk("p5_outst_coinc", 32'(outstanding_o), 32'd2);
    event_done = 1'b1; tick(2); event_done = 1'b0;
    chk("p5_outst_zero", 32'(outstanding_o), 32'd0);
    chk("p5_no_underflow", 32'(underflow_o), 32'd0);
    event_done = 1'b1; tick(1); event_done = 1'b0;
    tick(1);
    chk("p5_underflow", 32'(underflow_o), 32'd1);
    chk("p5_outst_stays", 32'(outstanding_o), 32'd0);

    // Dead time: ready low with trigger enabled for 100 cycles
    event_ready = 1'b0;
    tick(3);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("p6_dead_cleared", deadtime_o, 32'd0);
    tick(100);
    chk("p6_deadtime", deadtime_o, 32'd100);
    chk("p6_busy", 32'(busy_o), 32'd1);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("p6_dead_clear", deadtime_o, 32'd0);
    chk("p6_missed_clear", 32'(missed_o), 32'd0);

    tick(2);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("end_event_count", 32'(n_events), 32'(n_pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
